// File: rtl/memory_c_bptt_reader_pkg.sv
// Shared definitions for the memory_c backprop reader: FSM encoding and the
// cell-state memory layout rule also used by the memory_c writer control.
package memory_c_bptt_reader_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_CUR,
    S_RD_PREV,
    S_VALID,
    S_DONE
  } state_e;

  // Word address of c[t][n]; t=0 is the initial state.
  function automatic int unsigned cell_addr(input int unsigned t,
                                            input int unsigned n,
                                            input int unsigned num_lstm);
    return t * num_lstm + n;
  endfunction

endpackage

// File: rtl/memory_c_bptt_reader_if.sv
// Memory read port plus the (c_cur, c_prev) stream towards the backprop datapath.
interface memory_c_bptt_reader_if #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned ADDR_WIDTH = 9
);
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [WIDTH-1:0]      rd_data;
  logic                  o_valid;
  logic                  o_ready;
  logic [WIDTH-1:0]      c_cur;
  logic [WIDTH-1:0]      c_prev;
  logic [3:0]            t_idx;
  logic [5:0]            n_idx;
  logic                  o_last;

  modport master (
    output rd_addr,
    input  rd_data,
    output o_valid,
    input  o_ready,
    output c_cur,
    output c_prev,
    output t_idx,
    output n_idx,
    output o_last
  );

  modport slave (
    input  rd_addr,
    output rd_data,
    input  o_valid,
    output o_ready,
    input  c_cur,
    input  c_prev,
    input  t_idx,
    input  n_idx,
    input  o_last
  );
endinterface

// File: rtl/memory_c_bptt_reader.sv
// Reverse-time sweep over memory_c: for each (t,n), t=TIMESTEP..1, fetch c[t][n]
// and c[t-1][n] and present them as one valid/ready transfer.
module memory_c_bptt_reader
  import memory_c_bptt_reader_pkg::*;
#(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned NUM_LSTM   = 53,
  parameter int unsigned TIMESTEP   = 7,
  parameter int unsigned ADDR_WIDTH = 9
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  memory_c_bptt_reader_if.master   bus
);

  // base tracks t*NUM_LSTM and is stepped down by NUM_LSTM per timestep.
  localparam logic [ADDR_WIDTH-1:0] BASE_INIT = ADDR_WIDTH'(cell_addr(TIMESTEP, 0, NUM_LSTM));
  localparam logic [ADDR_WIDTH-1:0] STRIDE    = ADDR_WIDTH'(NUM_LSTM);
  localparam logic [3:0]            T_INIT    = 4'(TIMESTEP);
  localparam logic [5:0]            N_LAST    = 6'(NUM_LSTM - 1);

  state_e                state_q, state_d;
  logic [3:0]            t_q, t_d;
  logic [5:0]            n_q, n_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [WIDTH-1:0]      c_cur_q, c_cur_d;
  logic [WIDTH-1:0]      c_prev_q, c_prev_d;
  logic                  o_valid_q, o_valid_d;
  logic                  o_last_q, o_last_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [ADDR_WIDTH-1:0] rd_addr;

  always_comb begin
    state_d  = state_q;
    t_d      = t_q;
    n_d      = n_q;
    base_d   = base_q;
    c_cur_d  = c_cur_q;
    c_prev_d = c_prev_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RD_CUR;
          t_d     = T_INIT;
          n_d     = '0;
          base_d  = BASE_INIT;
        end
      end
      S_RD_CUR: begin
        c_cur_d = bus.rd_data;
        state_d = S_RD_PREV;
      end
      S_RD_PREV: begin
        c_prev_d = bus.rd_data;
        state_d  = S_VALID;
      end
      S_VALID: begin
        if (bus.o_ready) begin
          if (o_last_q) begin
            state_d = S_DONE;
          end else begin
            state_d = S_RD_CUR;
            if (n_q == N_LAST) begin
              n_d    = '0;
              t_d    = t_q - 4'd1;
              base_d = base_q - STRIDE;
            end else begin
              n_d = n_q + 6'd1;
            end
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Status outputs are registered, so derive them from the next state.
    o_valid_d = (state_d == S_VALID);
    o_last_d  = (state_d == S_VALID) && (t_d == 4'd1) && (n_d == N_LAST);
    busy_d    = (state_d != S_IDLE);
    done_d    = (state_d == S_DONE);
  end

  always_comb begin
    rd_addr = '0;
    case (state_q)
      S_RD_CUR:  rd_addr = base_q + ADDR_WIDTH'(n_q);
      S_RD_PREV: rd_addr = base_q - STRIDE + ADDR_WIDTH'(n_q);
      default:   rd_addr = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      t_q       <= '0;
      n_q       <= '0;
      base_q    <= '0;
      c_cur_q   <= '0;
      c_prev_q  <= '0;
      o_valid_q <= 1'b0;
      o_last_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      t_q       <= t_d;
      n_q       <= n_d;
      base_q    <= base_d;
      c_cur_q   <= c_cur_d;
      c_prev_q  <= c_prev_d;
      o_valid_q <= o_valid_d;
      o_last_q  <= o_last_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.rd_addr = rd_addr;
  assign bus.o_valid = o_valid_q;
  assign bus.c_cur   = c_cur_q;
  assign bus.c_prev  = c_prev_q;
  assign bus.t_idx   = t_q;
  assign bus.n_idx   = n_q;
  assign bus.o_last  = o_last_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule
